bin2bcd_seq: RTL and testbench

//   Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble),
//   one input bit per clock. Replaces the single-cycle combinational converter on the
//   7-segment display path: much shorter critical path, any input width, overflow detection
//   and a start/ready/done handshake. Sits between the arithmetic datapath and the

---
 rtl/bin2bcd_seq.sv | 101 ++++++++++
 tb/tb_bin2bcd_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock, start/ready/done handshake.
// Optional two's-complement input: define BIN2BCD_SIGNED_EN.
module bin2bcd_seq #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic                  neg
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FIN} state_t;

  state_t           state;
  logic [BIN_W-1:0] sreg;
  logic [BCD_W-1:0] work;
  logic [BCD_W-1:0] adj;
  logic             ovf;
  logic [CNT_W-1:0] cnt;
  logic [BIN_W-1:0] mag;

`ifdef BIN2BCD_SIGNED_EN
  logic sign_r;
  // Magnitude taken as unsigned BIN_W bits so the most negative value converts exactly.
  assign mag = bin[BIN_W-1] ? (~bin + BIN_W'(1)) : bin;
`else
  assign mag = bin;
  assign neg = 1'b0;
`endif

  // Digit correction: no carry leaves a digit, the top digit's MSB is what overflows.
  always_comb begin
    adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      adj[4*d +: 4] = work[4*d +: 4] + ((work[4*d +: 4] >= 4'd5) ? 4'd3 : 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      sreg     <= '0;
      work     <= '0;
      ovf      <= 1'b0;
      cnt      <= '0;
`ifdef BIN2BCD_SIGNED_EN
      sign_r   <= 1'b0;
      neg      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sreg  <= mag;
            work  <= '0;
            ovf   <= 1'b0;
            cnt   <= CNT_W'(BIN_W);
            ready <= 1'b0;
            state <= S_SHIFT;
`ifdef BIN2BCD_SIGNED_EN
            sign_r <= bin[BIN_W-1];
`endif
          end
        end
        S_SHIFT: begin
          work <= {adj[BCD_W-2:0], sreg[BIN_W-1]};
          sreg <= {sreg[BIN_W-2:0], 1'b0};
          ovf  <= ovf | adj[BCD_W-1];
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= S_FIN;
        end
        S_FIN: begin
          bcd      <= work;
          overflow <= ovf;
          done     <= 1'b1;
          ready    <= 1'b1;
          state    <= S_IDLE;
`ifdef BIN2BCD_SIGNED_EN
          neg      <= sign_r;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench: a 32-bit/10-digit and a 16-bit/4-digit converter, directed vectors.
module tb_bin2bcd_seq;

`ifdef BIN2BCD_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  typedef struct packed { logic [39:0] bcd; logic ovf; logic neg; } res_a_t;
  typedef struct packed { logic [15:0] bcd; logic ovf; logic neg; } res_b_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [31:0] bin_a = '0;
  logic [15:0] bin_b = '0;
  logic        ready_a, done_a, ovf_a, neg_a;
  logic        ready_b, done_b, ovf_b, neg_b;
  logic [39:0] bcd_a;
  logic [15:0] bcd_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  res_a_t exp_a[$];
  res_b_t exp_b[$];

  bin2bcd_seq #(.BIN_W(32), .DIGITS(10)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .bin(bin_a), .ready(ready_a),
    .done(done_a), .bcd(bcd_a), .overflow(ovf_a), .neg(neg_a));

  bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .bin(bin_b), .ready(ready_b),
    .done(done_b), .bcd(bcd_b), .overflow(ovf_b), .neg(neg_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done_a) begin
      if (exp_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_done got bcd %0h want no done", bcd_a);
      end else begin
        res_a_t e;
        e = exp_a.pop_front();
        chk("a_bcd", 64'(bcd_a), 64'(e.bcd));
        chk("a_ovf", 64'(ovf_a), 64'(e.ovf));
        chk("a_neg", 64'(neg_a), 64'(e.neg));
      end
    end
    if (!rst && done_b) begin
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_done got bcd %0h want no done", bcd_b);
      end else begin
        res_b_t e;
        e = exp_b.pop_front();
        chk("b_bcd", 64'(bcd_b), 64'(e.bcd));
        chk("b_ovf", 64'(ovf_b), 64'(e.ovf));
        chk("b_neg", 64'(neg_b), 64'(e.neg));
      end
    end
  end

  task automatic wait_ready_a();
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (ready_a) ok = 1'b1;
    end
    if (!ok) begin checks++; errors++; $display("FAIL a_ready_timeout got 0 want 1"); end
  endtask

  task automatic accept_a(input logic [31:0] v, input bit push, input logic [39:0] eb,
                          input logic eo, input logic en, output int t0);
    res_a_t e;
    wait_ready_a();
    e.bcd = eb; e.ovf = eo; e.neg = en;
    if (push) exp_a.push_back(e);
    start_a = 1'b1; bin_a = v;
    @(posedge clk); #1;
    start_a = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done_a(output int t);
    bit seen = 1'b0;
    t = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done_a) begin seen = 1'b1; t = cyc; end
    end
    if (!seen) begin checks++; errors++; $display("FAIL a_done_timeout got none want done"); end
  endtask

  task automatic go_a(input logic [31:0] v, input logic [39:0] eb, input logic eo, input logic en);
    int t0, t1;
    accept_a(v, 1'b1, eb, eo, en, t0);
    wait_done_a(t1);
    chk("a_latency", 64'(t1 - t0), 64'd33);
  endtask

  task automatic go_b(input logic [15:0] v, input logic [15:0] eb, input logic eo, input logic en);
    res_b_t e;
    int t0;
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (ready_b) ok = 1'b1;
    end
    e.bcd = eb; e.ovf = eo; e.neg = en;
    exp_b.push_back(e);
    start_b = 1'b1; bin_b = v;
    @(posedge clk); #1;
    start_b = 1'b0;
    t0 = cyc;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (done_b) ok = 1'b1;
    end
    chk("b_latency", 64'(ok ? cyc - t0 : -1), 64'd17);
  endtask

  initial begin
    int t0, t1, t2;
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_bcd", 64'(bcd_a), 64'd0);
    chk("rst_ready", 64'(ready_a), 64'd1);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_ovf", 64'(ovf_a), 64'd0);
    chk("rst_neg", 64'(neg_a), 64'd0);

    // Basic conversions on the wide instance
    go_a(32'd12345, 40'h00_0001_2345, 1'b0, 1'b0);
    go_a(32'hFFFF_FFFF, SGN ? 40'h1 : 40'h42_9496_7295, 1'b0, SGN);
    go_a(32'd0, 40'h0, 1'b0, 1'b0);
    go_a(32'h8000_0000, 40'h21_4748_3648, 1'b0, SGN);

    // Narrow instance: overflow keeps the low digits, flag clears per conversion
    go_b(16'd65535, SGN ? 16'h0001 : 16'h5535, ~SGN, SGN);
    go_b(16'd9999, 16'h9999, 1'b0, 1'b0);
    go_b(16'h8000, 16'h2768, 1'b1, SGN);
    go_b(16'd9999, 16'h9999, 1'b0, 1'b0);

    // start during conversion is ignored
    accept_a(32'd100, 1'b1, 40'h100, 1'b0, 1'b0, t0);
    repeat (5) @(negedge clk);
    chk("busy_ready", 64'(ready_a), 64'd0);
    start_a = 1'b1; bin_a = 32'd7;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a(t1);
    chk("ignored_latency", 64'(t1 - t0), 64'd33);

    // start held high: back-to-back conversions
    accept_a(32'd1, 1'b1, 40'h1, 1'b0, 1'b0, t0);
    start_a = 1'b1; bin_a = 32'd2;
    begin
      res_a_t e;
      e.bcd = 40'h2; e.ovf = 1'b0; e.neg = 1'b0;
      exp_a.push_back(e);
    end
    wait_done_a(t1);
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_done_a(t2);
    chk("b2b_spacing", 64'(t2 - t1), 64'd34);
    chk("b2b_first", 64'(t1 - t0), 64'd33);

    // Reset in the middle of a conversion aborts it
    accept_a(32'd999, 1'b0, 40'h0, 1'b0, 1'b0, t0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_bcd", 64'(bcd_a), 64'd0);
    chk("abort_ready", 64'(ready_a), 64'd1);
    chk("abort_done", 64'(done_a), 64'd0);
    repeat (50) @(negedge clk);
    go_a(32'd42, 40'h42, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_a_empty", 64'(exp_a.size()), 64'd0);
    chk("queue_b_empty", 64'(exp_b.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
